gnn_out_collector: RTL and testbench
====================================

# gnn_out_collector

Downstream stage of `gnn`. It captures the eight 20-bit signed per-node outputs (`out0`/`out1` for nodes 0–3) as their individual ready strobes rise. Once a full batch is held, it classifies each node by signed comparison of `out1` against `out0`. It then streams one result beat per node, in order node 0→3, over a valid/ready handshake to the host-side consumer.

## Interface
Parameters:
- `OUT_W`, 20: width of each `gnn` output; the margin is `OUT_W+1` bits wide.

Ports:
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `rst_n`, in, 1: synchronous, active-low reset.
- `outK_nodeN`, in, `OUT_W` signed: `gnn` outputs, K∈{0,1}, N∈{0..3}. Eight ports.
- `outK_ready_nodeN`, in, 1: matching ready strobe, level-held by `gnn`. Eight ports.
- `m_valid`, out, 1: result beat valid.
- `m_ready`, in, 1: consumer accepts the beat.
- `m_node`, out, 2: node index of the current beat.
- `m_out0`, out, `OUT_W` signed: captured `out0` for the node.
- `m_out1`, out, `OUT_W` signed: captured `out1` for the node.
- `m_class`, out, 1: 1 when `m_out1 > m_out0` (signed compare), else 0.
- `m_margin`, out, `OUT_W+1` signed: `m_out1 - m_out0`, exact, never saturates.
- `batch_done`, out, 1: one-cycle pulse after the node-3 beat is accepted.
- `err_overrun`, out, 1: sticky; set when a capture edge arrives during DRAIN.

## Operation
- **Slots:** 8 slots, each holding a value register, a full flag, and a registered copy `rdy_q` of its ready input.
- **Capture event:** `ready & ~rdy_q`, i.e. a rising edge. In COLLECT, an event with the slot empty loads the value and sets full.
- **Level-held ready:** a ready held high never recaptures. The input must drop low and rise again.
- **Duplicate edge:** a rising edge on an already-full slot in COLLECT is ignored and does not set `err_overrun`.
- **FSM states:** COLLECT and DRAIN. Reset state is COLLECT.
  - COLLECT → DRAIN when all 8 full flags are set; the node index is set to 0.
  - DRAIN: `m_valid`=1. Fields are driven from slot registers selected by the node index.
  - On `m_valid & m_ready`: index 0–2 increments. At index 3, the FSM returns to COLLECT, clears all full flags, and pulses `batch_done`.
- **Capture edges during DRAIN:** dropped, and `err_overrun` is set. It clears only on reset.
- **`rdy_q` tracking:** continues in all states, so an edge that occurred during DRAIN is not re-seen later.
- **Arithmetic:** both operands are sign-extended to `OUT_W+1` bits before subtraction. `m_class` is equivalent to `m_margin > 0`, so a tie gives class 0.

## Timing
- **Reset values:** `m_valid`, `m_node`, `m_out0`, `m_out1`, `m_class`, `m_margin`, `batch_done`, `err_overrun` = 0. All full flags = 0, all `rdy_q` = 0, state = COLLECT.
- **Ready already high at reset release:** counts as a rising edge in the first cycle after `rst_n` goes high.
- **Capture:** a ready edge sampled at edge T makes the slot full after T.
- **Latency:** `m_valid` is high from edge T+1, where T is the edge that filled the last slot.
- **Backpressure:** while `m_valid & ~m_ready`, all `m_*` outputs are held stable.
- **Throughput:** one beat per cycle under continuous `m_ready`; a batch drains in 4 cycles minimum.
- **`batch_done`:** high for the single cycle after the node-3 accept.
- **Next batch:** an edge in the cycle after the return to COLLECT is captured.
- **Reset mid-DRAIN:** `m_valid`=0 after that edge, the batch is discarded, and no `batch_done` is produced.

## Structure
- **`gnn_pkg`:** holds `OUT_W`=20, `NODE_CNT`=4, and the state enum (COLLECT, DRAIN).
- **`gnn_out_slot`:** sub-module containing edge detect, value register and full flag, with `capture_en`/`clear` inputs and a `hit_while_busy` output. Instantiated 8 times.
- **Top level:** the FSM, node index, output mux, subtractor, and `err_overrun`.

## Test plan
- **Simultaneous capture:** all readies rise in one cycle, with `out0_nodeN`=100·N and `out1_nodeN`=−50. `m_valid` asserts one cycle later. Beats for nodes 0..3 carry margins −50, −150, −250, −350, all class 0. `batch_done` pulses once.
- **Staggered with extremes:** readies rise over 8 separate cycles; node 2 has `out1`=524287 and `out0`=−524288. No `m_valid` appears before the 8th capture plus 1. Node 2 gives margin 1048575 and class 1.
- **Backpressure:** `m_ready` is held low for 3 cycles on the node-1 beat. Valid and all fields stay stable, and node 2 follows the first accept.
- **Tie and level hold:** `out0`=`out1`=7 on all nodes gives class 0 and margin 0. Readies held high after drain produce no second batch until they toggle low→high.
- **Overrun:** a ready rises low→high during DRAIN. `err_overrun`=1 and stays 1; the in-flight beat data is unchanged.
- **Reset mid-DRAIN:** `rst_n` is asserted at beat 2. `m_valid`=0 next cycle, all flags clear, and a fresh batch then drains normally.

Source files
------------

// File: rtl/gnn_pkg.sv
// Shared constants and FSM state encoding for the gnn output collector.
// Compile before the modules that import it.
package gnn_pkg;

    localparam int OUT_W    = 20;
    localparam int NODE_CNT = 4;
    localparam int SLOT_CNT = 2 * NODE_CNT;

    typedef enum logic {
        COLLECT = 1'b0,
        DRAIN   = 1'b1
    } state_t;

    // Exact difference b - a after sign extension by one bit.
    function automatic logic [OUT_W:0] signed_margin(
        input logic [OUT_W-1:0] a,
        input logic [OUT_W-1:0] b
    );
        return {b[OUT_W-1], b} - {a[OUT_W-1], a};
    endfunction

endpackage

// File: rtl/gnn_out_slot.sv
// One capture slot: ready rising-edge detect, value register and full flag.
// Latency: an edge sampled at edge T sets full after T. Never stalls.
module gnn_out_slot #(
    parameter int W = 20
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         ready,
    input  logic [W-1:0] value,
    input  logic         capture_en,
    input  logic         clear,
    output logic         full,
    output logic [W-1:0] data,
    output logic         hit_while_busy
);

    logic rdy_q;
    logic rise;

    assign rise           = ready & ~rdy_q;
    assign hit_while_busy = rise & ~capture_en;

    // rdy_q follows the input in every state so an edge is seen exactly once.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdy_q <= 1'b0;
            full  <= 1'b0;
            data  <= '0;
        end else begin
            rdy_q <= ready;
            if (clear) begin
                full <= 1'b0;
            end else if (rise && capture_en && !full) begin
                full <= 1'b1;
                data <= value;
            end
        end
    end

endmodule

// File: rtl/gnn_out_collector.sv
// Collects eight gnn outputs, classifies each node and streams four result beats.
// Latency: m_valid one cycle after the last capture; stalls hold all m_* stable.
module gnn_out_collector
    import gnn_pkg::*;
#(
    parameter int OUT_W = gnn_pkg::OUT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [OUT_W-1:0] out0_node0,
    input  logic [OUT_W-1:0] out0_node1,
    input  logic [OUT_W-1:0] out0_node2,
    input  logic [OUT_W-1:0] out0_node3,
    input  logic [OUT_W-1:0] out1_node0,
    input  logic [OUT_W-1:0] out1_node1,
    input  logic [OUT_W-1:0] out1_node2,
    input  logic [OUT_W-1:0] out1_node3,
    input  logic             out0_ready_node0,
    input  logic             out0_ready_node1,
    input  logic             out0_ready_node2,
    input  logic             out0_ready_node3,
    input  logic             out1_ready_node0,
    input  logic             out1_ready_node1,
    input  logic             out1_ready_node2,
    input  logic             out1_ready_node3,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [1:0]       m_node,
    output logic [OUT_W-1:0] m_out0,
    output logic [OUT_W-1:0] m_out1,
    output logic             m_class,
    output logic [OUT_W:0]   m_margin,
    output logic             batch_done,
    output logic             err_overrun
);

    // Slots 0..3 hold out0 of nodes 0..3, slots 4..7 hold out1.
    logic [OUT_W-1:0]    slot_in   [SLOT_CNT];
    logic [OUT_W-1:0]    slot_val  [SLOT_CNT];
    logic [SLOT_CNT-1:0] slot_rdy;
    logic [SLOT_CNT-1:0] slot_full;
    logic [SLOT_CNT-1:0] slot_hit;

    state_t     state;
    logic [1:0] node_idx;
    logic       capture_en;
    logic       last_accept;
    logic       all_full;
    logic       any_hit;

    logic [1:0]       sel_idx;
    logic [OUT_W-1:0] sel_out0;
    logic [OUT_W-1:0] sel_out1;
    logic [OUT_W:0]   sel_margin;
    logic             sel_class;

    assign slot_in[0] = out0_node0;
    assign slot_in[1] = out0_node1;
    assign slot_in[2] = out0_node2;
    assign slot_in[3] = out0_node3;
    assign slot_in[4] = out1_node0;
    assign slot_in[5] = out1_node1;
    assign slot_in[6] = out1_node2;
    assign slot_in[7] = out1_node3;

    assign slot_rdy = {out1_ready_node3, out1_ready_node2, out1_ready_node1, out1_ready_node0,
                       out0_ready_node3, out0_ready_node2, out0_ready_node1, out0_ready_node0};

    assign capture_en  = (state == COLLECT);
    assign last_accept = (state == DRAIN) && m_ready && (node_idx == 2'(NODE_CNT - 1));
    assign all_full    = &slot_full;
    assign any_hit     = |slot_hit;

    for (genvar i = 0; i < SLOT_CNT; i++) begin : g_slot
        gnn_out_slot #(
            .W(OUT_W)
        ) u_slot (
            .clk            (clk),
            .rst_n          (rst_n),
            .ready          (slot_rdy[i]),
            .value          (slot_in[i]),
            .capture_en     (capture_en),
            .clear          (last_accept),
            .full           (slot_full[i]),
            .data           (slot_val[i]),
            .hit_while_busy (slot_hit[i])
        );
    end

    // The output registers are loaded with the beat that becomes current next:
    // node 0 on entry to DRAIN, node_idx+1 on each non-final accept.
    always_comb begin
        sel_idx    = (state == COLLECT) ? 2'd0 : node_idx + 2'd1;
        sel_out0   = slot_val[{1'b0, sel_idx}];
        sel_out1   = slot_val[{1'b1, sel_idx}];
        sel_margin = signed_margin(sel_out0, sel_out1);
        sel_class  = ~sel_margin[OUT_W] & (|sel_margin);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= COLLECT;
            node_idx    <= 2'd0;
            m_valid     <= 1'b0;
            m_node      <= 2'd0;
            m_out0      <= '0;
            m_out1      <= '0;
            m_class     <= 1'b0;
            m_margin    <= '0;
            batch_done  <= 1'b0;
            err_overrun <= 1'b0;
        end else begin
            batch_done <= 1'b0;
            if (any_hit) begin
                err_overrun <= 1'b1;
            end
            case (state)
                COLLECT: begin
                    if (all_full) begin
                        state    <= DRAIN;
                        node_idx <= 2'd0;
                        m_valid  <= 1'b1;
                        m_node   <= sel_idx;
                        m_out0   <= sel_out0;
                        m_out1   <= sel_out1;
                        m_class  <= sel_class;
                        m_margin <= sel_margin;
                    end
                end
                DRAIN: begin
                    if (m_ready) begin
                        if (node_idx == 2'(NODE_CNT - 1)) begin
                            state      <= COLLECT;
                            m_valid    <= 1'b0;
                            batch_done <= 1'b1;
                        end else begin
                            node_idx <= sel_idx;
                            m_node   <= sel_idx;
                            m_out0   <= sel_out0;
                            m_out1   <= sel_out1;
                            m_class  <= sel_class;
                            m_margin <= sel_margin;
                        end
                    end
                end
                default: state <= COLLECT;
            endcase
        end
    end

endmodule

// File: tb/tb_gnn_out_collector.sv
// Directed bench for gnn_out_collector: capture, drain, stall, tie, overrun, reset.
module tb_gnn_out_collector;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [19:0] o0 [4];
    logic [19:0] o1 [4];
    logic [3:0]  r0 = '0;
    logic [3:0]  r1 = '0;
    logic        m_ready = 1'b0;

    logic        m_valid;
    logic [1:0]  m_node;
    logic [19:0] m_out0;
    logic [19:0] m_out1;
    logic        m_class;
    logic [20:0] m_margin;
    logic        batch_done;
    logic        err_overrun;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    gnn_out_collector #(.OUT_W(20)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .out0_node0       (o0[0]),
        .out0_node1       (o0[1]),
        .out0_node2       (o0[2]),
        .out0_node3       (o0[3]),
        .out1_node0       (o1[0]),
        .out1_node1       (o1[1]),
        .out1_node2       (o1[2]),
        .out1_node3       (o1[3]),
        .out0_ready_node0 (r0[0]),
        .out0_ready_node1 (r0[1]),
        .out0_ready_node2 (r0[2]),
        .out0_ready_node3 (r0[3]),
        .out1_ready_node0 (r1[0]),
        .out1_ready_node1 (r1[1]),
        .out1_ready_node2 (r1[2]),
        .out1_ready_node3 (r1[3]),
        .m_valid          (m_valid),
        .m_ready          (m_ready),
        .m_node           (m_node),
        .m_out0           (m_out0),
        .m_out1           (m_out1),
        .m_class          (m_class),
        .m_margin         (m_margin),
        .batch_done       (batch_done),
        .err_overrun      (err_overrun)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_beat(input string tag, input logic [1:0] node, input logic [19:0] v0,
                            input logic [19:0] v1, input logic cls, input logic [20:0] mar);
        chk({tag, ".valid"}, 64'(m_valid), 64'd1);
        chk({tag, ".node"}, 64'(m_node), 64'(node));
        chk({tag, ".out0"}, 64'(m_out0), 64'(v0));
        chk({tag, ".out1"}, 64'(m_out1), 64'(v1));
        chk({tag, ".class"}, 64'(m_class), 64'(cls));
        chk({tag, ".margin"}, 64'(m_margin), 64'(mar));
    endtask

    initial begin
        for (int n = 0; n < 4; n++) begin
            o0[n] = '0;
            o1[n] = '0;
        end

        // Reset values
        step();
        step();
        chk("rst.valid", 64'(m_valid), 64'd0);
        chk("rst.node", 64'(m_node), 64'd0);
        chk("rst.margin", 64'(m_margin), 64'd0);
        chk("rst.out0", 64'(m_out0), 64'd0);
        chk("rst.done", 64'(batch_done), 64'd0);
        chk("rst.err", 64'(err_overrun), 64'd0);

        // Simultaneous capture: out0 = 100*N, out1 = -50
        for (int n = 0; n < 4; n++) begin
            o0[n] = 20'(100 * n);
            o1[n] = 20'(-50);
        end
        rst_n = 1'b1;
        r0 = 4'hF;
        r1 = 4'hF;
        step();
        chk("sim.novalid", 64'(m_valid), 64'd0);
        step();
        chk_beat("sim.b0", 2'd0, 20'd0, 20'(-50), 1'b0, 21'(-50));
        m_ready = 1'b1;
        step();
        chk_beat("sim.b1", 2'd1, 20'd100, 20'(-50), 1'b0, 21'(-150));
        step();
        chk_beat("sim.b2", 2'd2, 20'd200, 20'(-50), 1'b0, 21'(-250));
        step();
        chk_beat("sim.b3", 2'd3, 20'd300, 20'(-50), 1'b0, 21'(-350));
        chk("sim.done_early", 64'(batch_done), 64'd0);
        step();
        chk("sim.done", 64'(batch_done), 64'd1);
        chk("sim.valid_off", 64'(m_valid), 64'd0);
        step();
        chk("sim.done_once", 64'(batch_done), 64'd0);
        chk("sim.no_rebatch", 64'(m_valid), 64'd0);

        // Staggered captures with extreme values on node 2
        r0 = '0;
        r1 = '0;
        m_ready = 1'b0;
        step();
        o0[0] = 20'd10;          o1[0] = 20'd20;
        o0[1] = 20'd5;           o1[1] = 20'(-5);
        o0[2] = 20'(-524288);    o1[2] = 20'd524287;
        o0[3] = 20'(-1);         o1[3] = 20'(-1);
        for (int i = 0; i < 8; i++) begin
            if (i < 4) r0[i] = 1'b1;
            else       r1[i-4] = 1'b1;
            step();
            chk($sformatf("stg.novalid%0d", i), 64'(m_valid), 64'd0);
        end
        step();
        chk_beat("stg.b0", 2'd0, 20'd10, 20'd20, 1'b1, 21'd10);

        // Backpressure on the node-1 beat
        m_ready = 1'b1;
        step();
        m_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            chk_beat($sformatf("bp.hold%0d", c), 2'd1, 20'd5, 20'(-5), 1'b0, 21'(-10));
            step();
        end
        chk_beat("bp.hold3", 2'd1, 20'd5, 20'(-5), 1'b0, 21'(-10));
        m_ready = 1'b1;
        step();
        chk_beat("stg.b2", 2'd2, 20'h80000, 20'h7FFFF, 1'b1, 21'd1048575);
        step();
        chk_beat("stg.b3", 2'd3, 20'hFFFFF, 20'hFFFFF, 1'b0, 21'd0);
        step();
        chk("stg.done", 64'(batch_done), 64'd1);

        // Tie and level hold: readies stay high, nothing recaptures
        for (int n = 0; n < 4; n++) begin
            o0[n] = 20'd7;
            o1[n] = 20'd7;
        end
        m_ready = 1'b0;
        step();
        step();
        step();
        chk("lvl.novalid", 64'(m_valid), 64'd0);
        r0 = '0;
        r1 = '0;
        step();
        r0 = 4'hF;
        r1 = 4'hF;
        step();
        chk("tie.novalid", 64'(m_valid), 64'd0);
        step();
        chk_beat("tie.b0", 2'd0, 20'd7, 20'd7, 1'b0, 21'd0);

        // Overrun: ready toggles during DRAIN, in-flight beat untouched
        r0[0] = 1'b0;
        step();
        chk("ovr.pre", 64'(err_overrun), 64'd0);
        r0[0] = 1'b1;
        o0[0] = 20'd999;
        step();
        chk("ovr.set", 64'(err_overrun), 64'd1);
        chk_beat("ovr.b0", 2'd0, 20'd7, 20'd7, 1'b0, 21'd0);
        m_ready = 1'b1;
        step();
        chk_beat("tie.b1", 2'd1, 20'd7, 20'd7, 1'b0, 21'd0);
        chk("ovr.sticky", 64'(err_overrun), 64'd1);
        step();
        chk("rdr.b2", 64'(m_node), 64'd2);

        // Reset mid-DRAIN at beat 2, then a fresh batch from held-high readies
        rst_n = 1'b0;
        for (int n = 0; n < 4; n++) begin
            o0[n] = 20'(n);
            o1[n] = 20'd10;
        end
        step();
        chk("rdr.valid", 64'(m_valid), 64'd0);
        chk("rdr.node", 64'(m_node), 64'd0);
        chk("rdr.err", 64'(err_overrun), 64'd0);
        chk("rdr.done", 64'(batch_done), 64'd0);
        rst_n = 1'b1;
        step();
        chk("rdr.novalid", 64'(m_valid), 64'd0);
        step();
        chk_beat("new.b0", 2'd0, 20'd0, 20'd10, 1'b1, 21'd10);
        step();
        chk_beat("new.b1", 2'd1, 20'd1, 20'd10, 1'b1, 21'd9);
        step();
        chk_beat("new.b2", 2'd2, 20'd2, 20'd10, 1'b1, 21'd8);
        step();
        chk_beat("new.b3", 2'd3, 20'd3, 20'd10, 1'b1, 21'd7);
        step();
        chk("new.done", 64'(batch_done), 64'd1);
        chk("new.err", 64'(err_overrun), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
